// File: rtl/m3_motionsched.sv
// m3_motionsched: host command sequencer that drives m3_stepCalc toward a target round period.
// Build macro M3_SOFTSTOP_EN: a stop in RUN ramps the motor down before forcing the stop.
module m3_motionsched #(
  parameter logic [21:0] PERIOD_MIN = 22'd40,
  parameter logic [21:0] PERIOD_MAX = 22'd4000000,
  parameter logic [21:0] HYST       = 22'd2,
  parameter logic [23:0] STALL_CLKS = 24'd8000000
) (
  input  logic        clkI,
  input  logic        rstI,
  input  logic        cmdValidI,
  output logic        cmdReadyO,
  input  logic [1:0]  cmdOpI,
  input  logic [21:0] cmdPeriodI,
  input  logic        roundTickI,
  input  logic        faultI,
  output logic        m3startO,
  output logic        m3forceStopO,
  output logic        m3invRotateO,
  output logic        m3speedINCo,
  output logic        m3speedDECo,
  output logic        m3powerINCo,
  output logic        m3powerDECo,
  output logic [2:0]  stateO,
  output logic [21:0] measPeriodO
);
  localparam int unsigned PW = 22;
  localparam int unsigned SW = 24;
  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_SET   = 2'd2;
  localparam logic [1:0] OP_REV   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_REV_DOWN  = 3'd2,
    ST_REV_FLIP  = 3'd3,
    ST_STOPPING  = 3'd4,
    ST_FAULT     = 3'd5,
    ST_SOFT_DOWN = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] target_q, target_d, saved_q, saved_d, meas_q, meas_d, per_cnt_q, per_cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          mv_q, mv_d, flip_q, flip_d, inv_q, inv_d;
  logic          start_q, start_d, fstop_q, fstop_d, inc_q, inc_d, dec_q, dec_d;
  logic          pinc_q, pinc_d, pdec_q, pdec_d, ready_q, ready_d;
  logic          cmd_fire, running, stall_hit, ramp_done, fault_go;
  logic [PW-1:0] tgt_clamp;
  logic [1:0]    spd;

  function automatic logic [PW-1:0] clamp_period(input logic [PW-1:0] p);
    if (p < PERIOD_MIN)      return PERIOD_MIN;
    else if (p > PERIOD_MAX) return PERIOD_MAX;
    else                     return p;
  endfunction

  // Returns {inc, dec}; the low-side band edge is formed as meas+HYST to avoid underflow.
  function automatic logic [1:0] speed_ctl(input logic [PW-1:0] tgt, input logic [PW-1:0] meas,
                                           input logic valid);
    logic [PW:0] t_ext, m_ext;
    t_ext = {1'b0, tgt};
    m_ext = {1'b0, meas};
    if (!valid)                               return {(tgt < PERIOD_MAX), 1'b0};
    else if (m_ext > t_ext + (PW+1)'(HYST))   return 2'b10;
    else if (m_ext + (PW+1)'(HYST) < t_ext)   return 2'b01;
    else                                      return 2'b00;
  endfunction

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    saved_d   = saved_q;
    meas_d    = meas_q;
    per_cnt_d = per_cnt_q;
    stall_d   = stall_q;
    mv_d      = mv_q;
    flip_d    = flip_q;
    inv_d     = inv_q;
    pinc_d    = 1'b0;
    pdec_d    = 1'b0;
    start_d   = 1'b0;
    fstop_d   = 1'b0;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    ready_d   = 1'b1;
    spd       = 2'b00;

    cmd_fire  = cmdValidI & ready_q;
    tgt_clamp = clamp_period(cmdPeriodI);
    running   = (state_q == ST_RUN) || (state_q == ST_REV_DOWN) || (state_q == ST_SOFT_DOWN);
    stall_hit = running && !roundTickI && (stall_q == STALL_CLKS - 24'd1);
    ramp_done = mv_q && (meas_q >= PERIOD_MAX - HYST);
    fault_go  = (faultI && (state_q != ST_IDLE)) || stall_hit;

    // Round-period measurement and stall watchdog while the motor is commanded to run
    if (running) begin
      pinc_d = roundTickI & inc_q;
      pdec_d = roundTickI & dec_q;
      if (roundTickI) begin
        meas_d    = per_cnt_q;
        per_cnt_d = 22'd1;
        mv_d      = 1'b1;
        stall_d   = '0;
      end else begin
        if (per_cnt_q != 22'h3FFFFF) per_cnt_d = per_cnt_q + 22'd1;
        stall_d = stall_q + 24'd1;
      end
    end else begin
      per_cnt_d = '0;
      stall_d   = '0;
    end

    if (fault_go) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            case (cmdOpI)
              OP_START: begin target_d = tgt_clamp; mv_d = 1'b0; state_d = ST_RUN; end
              OP_SET:   target_d = tgt_clamp;
              OP_REV:   inv_d = ~inv_q;
              default:  ;
            endcase
          end
        end
        ST_RUN: begin
          if (cmd_fire) begin
            case (cmdOpI)
              OP_START, OP_SET: target_d = tgt_clamp;
              OP_STOP: begin
`ifdef M3_SOFTSTOP_EN
                target_d = PERIOD_MAX;
                state_d  = ST_SOFT_DOWN;
`else
                state_d  = ST_STOPPING;
`endif
              end
              default: begin saved_d = target_q; target_d = PERIOD_MAX; state_d = ST_REV_DOWN; end
            endcase
          end
        end
        ST_REV_DOWN: begin
          if (ramp_done) begin state_d = ST_REV_FLIP; flip_d = 1'b0; inv_d = ~inv_q; end
        end
        ST_REV_FLIP: begin
          if (!flip_q) flip_d = 1'b1;
          else begin target_d = saved_q; mv_d = 1'b0; state_d = ST_RUN; end
        end
        ST_STOPPING: state_d = ST_IDLE;
        ST_FAULT: begin
          if (cmd_fire && (cmdOpI == OP_STOP) && !faultI) state_d = ST_IDLE;
        end
        ST_SOFT_DOWN: begin
          if (ramp_done) state_d = ST_STOPPING;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Outputs are derived from next-cycle values so they line up with stateO
    spd = speed_ctl(target_d, meas_d, mv_d);
    case (state_d)
      ST_RUN:                    begin start_d = 1'b1; inc_d = spd[1]; dec_d = spd[0]; end
      ST_REV_DOWN, ST_SOFT_DOWN: begin start_d = 1'b1; dec_d = 1'b1; ready_d = 1'b0; end
      ST_REV_FLIP:               ready_d = 1'b0;
      ST_STOPPING:               begin fstop_d = 1'b1; ready_d = 1'b0; end
      ST_FAULT:                  fstop_d = 1'b1;
      default:                   ;
    endcase
  end

  always_ff @(posedge clkI) begin
    if (rstI) begin
      state_q   <= ST_IDLE;
      target_q  <= PERIOD_MAX;
      saved_q   <= PERIOD_MAX;
      meas_q    <= '0;
      per_cnt_q <= '0;
      stall_q   <= '0;
      mv_q      <= 1'b0;
      flip_q    <= 1'b0;
      inv_q     <= 1'b0;
      start_q   <= 1'b0;
      fstop_q   <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      pinc_q    <= 1'b0;
      pdec_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      saved_q   <= saved_d;
      meas_q    <= meas_d;
      per_cnt_q <= per_cnt_d;
      stall_q   <= stall_d;
      mv_q      <= mv_d;
      flip_q    <= flip_d;
      inv_q     <= inv_d;
      start_q   <= start_d;
      fstop_q   <= fstop_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
      pinc_q    <= pinc_d;
      pdec_q    <= pdec_d;
      ready_q   <= ready_d;
    end
  end

  assign cmdReadyO    = ready_q;
  assign m3startO     = start_q;
  assign m3forceStopO = fstop_q;
  assign m3invRotateO = inv_q;
  assign m3speedINCo  = inc_q;
  assign m3speedDECo  = dec_q;
  assign m3powerINCo  = pinc_q;
  assign m3powerDECo  = pdec_q;
  assign stateO       = state_q;
  assign measPeriodO  = meas_q;
endmodule

// File: tb/tb_m3_motionsched.sv
// Directed bench for m3_motionsched with a shortened PERIOD_MAX and stall window.
module tb_m3_motionsched;
  logic        clkI = 1'b0;
  logic        rstI, cmdValidI, cmdReadyO, roundTickI, faultI;
  logic [1:0]  cmdOpI;
  logic [21:0] cmdPeriodI;
  logic        m3startO, m3forceStopO, m3invRotateO;
  logic        m3speedINCo, m3speedDECo, m3powerINCo, m3powerDECo;
  logic [2:0]  stateO;
  logic [21:0] measPeriodO;

  int vectors = 0;
  int miscompares = 0;

  m3_motionsched #(
    .PERIOD_MIN(22'd40), .PERIOD_MAX(22'd1000), .HYST(22'd2), .STALL_CLKS(24'd1200)
  ) dut (
    .clkI(clkI), .rstI(rstI), .cmdValidI(cmdValidI), .cmdReadyO(cmdReadyO),
    .cmdOpI(cmdOpI), .cmdPeriodI(cmdPeriodI), .roundTickI(roundTickI), .faultI(faultI),
    .m3startO(m3startO), .m3forceStopO(m3forceStopO), .m3invRotateO(m3invRotateO),
    .m3speedINCo(m3speedINCo), .m3speedDECo(m3speedDECo),
    .m3powerINCo(m3powerINCo), .m3powerDECo(m3powerDECo),
    .stateO(stateO), .measPeriodO(measPeriodO)
  );

  always #5 clkI = ~clkI;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clkI);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [21:0] per);
    cmdValidI = 1'b1; cmdOpI = op; cmdPeriodI = per;
    step(1);
    cmdValidI = 1'b0;
  endtask

  task automatic tick();
    roundTickI = 1'b1;
    step(1);
    roundTickI = 1'b0;
  endtask

  task automatic tick_gap(input int t);
    step(t - 1);
    tick();
  endtask

  initial begin
    rstI = 1'b1; cmdValidI = 1'b0; cmdOpI = 2'd0; cmdPeriodI = '0;
    roundTickI = 1'b0; faultI = 1'b0;
    step(2);
    chk("rst_ready", 32'(cmdReadyO), 1);
    chk("rst_state", 32'(stateO), 0);
    chk("rst_start", 32'(m3startO), 0);
    chk("rst_fstop", 32'(m3forceStopO), 0);
    chk("rst_inv", 32'(m3invRotateO), 0);
    chk("rst_incdec", 32'({m3speedINCo, m3speedDECo, m3powerINCo, m3powerDECo}), 0);
    chk("rst_meas", 32'(measPeriodO), 0);
    rstI = 1'b0;

    // start: RUN with INC while no measurement exists
    send(2'd0, 22'd100);
    chk("start_state", 32'(stateO), 1);
    chk("start_m3start", 32'(m3startO), 1);
    chk("start_inc", 32'(m3speedINCo), 1);
    chk("start_dec", 32'(m3speedDECo), 0);

    // retarget to 10 -> clamped 40; first tick measures counter value 1
    send(2'd0, 22'd10);
    tick();
    chk("first_meas", 32'(measPeriodO), 1);
    chk("first_dec", 32'(m3speedDECo), 1);
    chk("first_pinc", 32'(m3powerINCo), 1);
    tick_gap(41);
    chk("clamp_meas", 32'(measPeriodO), 41);
    chk("clamp_band", 32'({m3speedINCo, m3speedDECo}), 0);
    chk("clamp_pdec", 32'({m3powerINCo, m3powerDECo}), 1);

    // target 200 with several tick spacings
    send(2'd2, 22'd200);
    tick();
    tick_gap(250);
    chk("s250_incdec", 32'({m3speedINCo, m3speedDECo}), 2);
    tick_gap(250);
    chk("s250_pinc", 32'({m3powerINCo, m3powerDECo}), 2);
    step(1);
    chk("pinc_oneshot", 32'(m3powerINCo), 0);
    step(188);
    tick();
    chk("s190_incdec", 32'({m3speedINCo, m3speedDECo}), 1);
    tick_gap(201);
    chk("s201_incdec", 32'({m3speedINCo, m3speedDECo}), 0);
    tick_gap(203);
    chk("s203_incdec", 32'({m3speedINCo, m3speedDECo}), 2);
    tick_gap(197);
    chk("s197_incdec", 32'({m3speedINCo, m3speedDECo}), 1);
    tick_gap(198);
    chk("s198_incdec", 32'({m3speedINCo, m3speedDECo}), 0);

    // reverse from RUN at target 100
    send(2'd2, 22'd100);
    send(2'd3, 22'd0);
    chk("rev_state", 32'(stateO), 2);
    chk("rev_ready", 32'(cmdReadyO), 0);
    chk("rev_incdec", 32'({m3speedINCo, m3speedDECo}), 1);
    chk("rev_start", 32'(m3startO), 1);
    tick();
    chk("rev_pdec", 32'(m3powerDECo), 1);
    tick_gap(500);
    chk("rev500_state", 32'(stateO), 2);
    tick_gap(997);
    step(1);
    chk("rev997_state", 32'(stateO), 2);
    step(996);
    tick();
    chk("rev998_meas", 32'(measPeriodO), 998);
    chk("rev998_state", 32'(stateO), 2);
    step(1);
    chk("flip1_state", 32'(stateO), 3);
    chk("flip1_start", 32'(m3startO), 0);
    chk("flip1_inv", 32'(m3invRotateO), 1);
    chk("flip1_ready", 32'(cmdReadyO), 0);
    step(1);
    chk("flip2_state", 32'(stateO), 3);
    chk("flip2_start", 32'(m3startO), 0);
    step(1);
    chk("back_state", 32'(stateO), 1);
    chk("back_start", 32'(m3startO), 1);
    chk("back_inc", 32'(m3speedINCo), 1);
    tick();
    tick_gap(100);
    chk("back_t100", 32'({m3speedINCo, m3speedDECo}), 0);

    // fault during REV_DOWN, stop only honoured once fault clears
    send(2'd3, 22'd0);
    chk("rev2_state", 32'(stateO), 2);
    faultI = 1'b1;
    step(1);
    chk("fault_state", 32'(stateO), 5);
    chk("fault_fstop", 32'(m3forceStopO), 1);
    chk("fault_start", 32'(m3startO), 0);
    chk("fault_incdec", 32'({m3speedINCo, m3speedDECo}), 0);
    chk("fault_ready", 32'(cmdReadyO), 1);
    send(2'd1, 22'd0);
    chk("fault_stop_held", 32'(stateO), 5);
    faultI = 1'b0;
    send(2'd2, 22'd300);
    chk("fault_set_drop", 32'(stateO), 5);
    send(2'd1, 22'd0);
    chk("fault_exit", 32'(stateO), 0);
    chk("fault_exit_fstop", 32'(m3forceStopO), 0);

    // IDLE behaviour
    faultI = 1'b1;
    step(1);
    chk("idle_fault_ign", 32'(stateO), 0);
    faultI = 1'b0;
    send(2'd3, 22'd0);
    chk("idle_rev_inv", 32'(m3invRotateO), 0);
    send(2'd2, 22'd50);
    chk("idle_set_state", 32'(stateO), 0);
    chk("idle_set_start", 32'(m3startO), 0);
    send(2'd0, 22'd3000);
    chk("clampmax_state", 32'(stateO), 1);
    chk("clampmax_inc", 32'(m3speedINCo), 0);

    // stop from RUN
    send(2'd1, 22'd0);
`ifdef M3_SOFTSTOP_EN
    chk("soft_state", 32'(stateO), 6);
    chk("soft_dec", 32'(m3speedDECo), 1);
    chk("soft_ready", 32'(cmdReadyO), 0);
    tick();
    tick_gap(999);
    step(1);
`endif
    chk("stop_state", 32'(stateO), 4);
    chk("stop_fstop", 32'(m3forceStopO), 1);
    chk("stop_start", 32'(m3startO), 0);
    chk("stop_incdec", 32'({m3speedINCo, m3speedDECo}), 0);
    step(1);
    chk("stop_idle", 32'(stateO), 0);
    chk("stop_fstop_off", 32'(m3forceStopO), 0);
    chk("stop_ready", 32'(cmdReadyO), 1);

    // fault beats a same-cycle stop command
    send(2'd0, 22'd100);
    faultI = 1'b1;
    send(2'd1, 22'd0);
    chk("fault_prio", 32'(stateO), 5);
    faultI = 1'b0;
    send(2'd1, 22'd0);
    chk("fault_prio_exit", 32'(stateO), 0);

    // stall: 1200 cycles without a round tick
    send(2'd0, 22'd100);
    step(1199);
    chk("stall_pre", 32'(stateO), 1);
    step(1);
    chk("stall_state", 32'(stateO), 5);
    chk("stall_fstop", 32'(m3forceStopO), 1);
    send(2'd1, 22'd0);
    chk("stall_exit", 32'(stateO), 0);

    // synchronous reset from RUN
    send(2'd0, 22'd100);
    rstI = 1'b1;
    step(1);
    rstI = 1'b0;
    chk("rerst_state", 32'(stateO), 0);
    chk("rerst_start", 32'(m3startO), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
